// File: rtl/fetch_unit_buffered.sv
// Buffered instruction fetch stage: pipelined imem requests with credit-based
// flow control, an in-order fetch queue to decode, and redirect flush/drop.
module fetch_unit_buffered #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              FQ_DEPTH  = 4,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jalr_valid,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            branch_valid,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4
);

    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [ILEN-1:0] r_q_instr [FQ_DEPTH];
    logic [XLEN-1:0] r_q_pc    [FQ_DEPTH];
    logic [AW-1:0]   r_q_head;
    logic [AW-1:0]   r_q_tail;
    logic [CW-1:0]   r_q_count;

    logic [XLEN-1:0] r_pf_pc   [FQ_DEPTH];
    logic [AW-1:0]   r_pf_head;
    logic [AW-1:0]   r_pf_tail;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic [CW:0]     w_credit;
    logic            w_accept;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;

    assign w_redirect = jalr_valid | branch_valid;
    assign w_target   = jalr_valid ? jalr_target : branch_target;

    // Queued plus in-flight never exceeds the queue size, so responses always fit.
    assign w_credit = {1'b0, r_q_count} + {1'b0, r_outstanding};

    assign imem_req_valid = rst & ~w_redirect & (r_drop_cnt == '0)
                          & (w_credit < (CW+1)'(FQ_DEPTH));
    assign imem_req_addr  = r_pc;

    assign w_accept = imem_req_valid & imem_req_ready;
    assign w_drop   = imem_rsp_valid & (r_drop_cnt != '0);
    assign w_push   = imem_rsp_valid & (r_drop_cnt == '0) & ~w_redirect;
    assign w_empty  = (r_q_count == '0);
    assign w_pop    = ~w_empty & dec_ready & ~w_redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_q_head      <= '0;
            r_q_tail      <= '0;
            r_q_count     <= '0;
            r_pf_head     <= '0;
            r_pf_tail     <= '0;
        end else if (w_redirect) begin
            // Everything still in flight is stale; a response this cycle retires one.
            r_pc          <= w_target;
            r_outstanding <= r_outstanding - CW'(imem_rsp_valid);
            r_drop_cnt    <= r_outstanding - CW'(imem_rsp_valid);
            r_q_head      <= '0;
            r_q_tail      <= '0;
            r_q_count     <= '0;
            r_pf_head     <= '0;
            r_pf_tail     <= '0;
        end else begin
            if (w_accept) begin
                r_pc      <= r_pc + XLEN'(4);
                r_pf_tail <= r_pf_tail + AW'(1);
            end
            if (w_push) begin
                r_pf_head <= r_pf_head + AW'(1);
                r_q_tail  <= r_q_tail + AW'(1);
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            if (w_pop) begin
                r_q_head <= r_q_head + AW'(1);
            end
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);
            r_q_count     <= r_q_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pf_pc[r_pf_tail] <= r_pc;
        end
        if (w_push) begin
            r_q_instr[r_q_tail] <= imem_rsp_data;
            r_q_pc[r_q_tail]    <= r_pf_pc[r_pf_head];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(w_push && !w_pop && (r_q_count == CW'(FQ_DEPTH))));
        end
    end

    assign dec_valid    = ~w_empty;
    assign dec_instr    = w_empty ? NOP_INSTR : r_q_instr[r_q_head];
    assign dec_pc       = w_empty ? '0 : r_q_pc[r_q_head];
    assign dec_pc_plus4 = w_empty ? '0 : r_q_pc[r_q_head] + XLEN'(4);

endmodule

// File: tb/tb_fetch_unit_buffered.sv
// Directed bench for fetch_unit_buffered: queue-based reference model checked
// every cycle, plus hand-computed literal expectations for key scenarios.
module tb_fetch_unit_buffered;

    localparam int          FQ_DEPTH = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jalr_valid = 1'b0;
    logic [31:0] jalr_target = '0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;

    fetch_unit_buffered #(
        .XLEN(32), .ILEN(32), .RESET_PC(32'h0), .FQ_DEPTH(FQ_DEPTH), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .jalr_valid(jalr_valid), .jalr_target(jalr_target),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit stale; } flight_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } entry_t;
    typedef struct { logic [31:0] addr; int due; } memreq_t;

    flight_t     inflight[$];
    entry_t      fq[$];
    memreq_t     mq[$];
    logic [31:0] mPc;

    int cyc, vectors, miscompares, nAccepts;

    logic        sRst, sDecReady, sReqReady, sJalrV, sBrV;
    logic [31:0] sJalrT, sBrT;
    int          sLat;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic bit modelReqValid();
        bit anyStale = 1'b0;
        foreach (inflight[i]) if (inflight[i].stale) anyStale = 1'b1;
        return sRst && !(sJalrV || sBrV) && !anyStale
            && ((fq.size() + inflight.size()) < FQ_DEPTH);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic compareModel();
        bit expReq;
        expReq = modelReqValid();
        checkOutput("req_valid", {31'b0, imem_req_valid}, {31'b0, expReq});
        if (expReq) checkOutput("req_addr", imem_req_addr, mPc);
        checkOutput("dec_valid", {31'b0, dec_valid}, {31'b0, fq.size() > 0});
        checkOutput("dec_instr", dec_instr, (fq.size() > 0) ? fq[0].instr : NOP);
        checkOutput("dec_pc", dec_pc, (fq.size() > 0) ? fq[0].pc : 32'h0);
        checkOutput("dec_pc_plus4", dec_pc_plus4, (fq.size() > 0) ? fq[0].pc + 32'd4 : 32'h0);
    endtask

    // What the rising edge that closes the current cycle does to the model and memory.
    task automatic advanceModel();
        bit      redirect, accept, dutAccept;
        flight_t f;
        redirect  = sJalrV || sBrV;
        accept    = modelReqValid() && sReqReady;
        dutAccept = imem_req_valid && imem_req_ready;
        if (dutAccept) nAccepts++;
        if (!sRst) return;
        if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
        if (dutAccept) mq.push_back('{imem_req_addr, cyc + sLat});
        if (fq.size() > 0 && sDecReady && !redirect) void'(fq.pop_front());
        if (imem_rsp_valid && inflight.size() > 0) begin
            f = inflight.pop_front();
            if (!f.stale && !redirect) fq.push_back('{memData(f.pc), f.pc});
        end
        if (redirect) begin
            fq.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            mPc = sJalrV ? sJalrT : sBrT;
        end else if (accept) begin
            inflight.push_back('{mPc, 1'b0});
            mPc = mPc + 32'd4;
        end
    endtask

    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst            = sRst;
            dec_ready      = sDecReady;
            imem_req_ready = sReqReady;
            jalr_valid     = sJalrV;
            jalr_target    = sJalrT;
            branch_valid   = sBrV;
            branch_target  = sBrT;
            if (!sRst) begin
                mq.delete();
                inflight.delete();
                fq.delete();
                mPc = 32'h0;
            end
            if (sRst && mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memData(mq[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
            #1;
            compareModel();
            advanceModel();
            cyc++;
        end
    endtask

    task automatic doReset();
        sRst = 1'b0;
        sJalrV = 1'b0;
        sBrV = 1'b0;
        applyStimulus(2);
        sRst = 1'b1;
        nAccepts = 0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; nAccepts = 0;
        sRst = 1'b0; sDecReady = 1'b1; sReqReady = 1'b1;
        sJalrV = 1'b0; sBrV = 1'b0; sJalrT = '0; sBrT = '0; sLat = 1;
        mPc = 32'h0;

        applyStimulus(2);
        checkOutput("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
        checkOutput("rst_dec_instr", dec_instr, 32'h0000_0013);
        checkOutput("rst_dec_pc", dec_pc, 32'h0);
        checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);

        // Streaming with a 1-cycle memory
        sRst = 1'b1;
        applyStimulus(3);
        checkOutput("lit_dec_pc_c2", dec_pc, 32'h0);
        checkOutput("lit_req_addr_c2", imem_req_addr, 32'h8);
        applyStimulus(1);
        checkOutput("lit_dec_pc_c3", dec_pc, 32'h4);
        checkOutput("lit_dec_pc4_c3", dec_pc_plus4, 32'h8);
        checkOutput("lit_dec_instr_c3", dec_instr, 32'hDEAD_0004);
        applyStimulus(6);

        // Decode stall fills the queue with exactly FQ_DEPTH fetches
        doReset();
        sDecReady = 1'b0;
        applyStimulus(10);
        checkOutput("lit_stall_reqs", nAccepts, 32'd4);
        checkOutput("lit_stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
        checkOutput("lit_stall_head", dec_pc, 32'h0);
        sDecReady = 1'b1;
        applyStimulus(4);
        checkOutput("lit_release_head", dec_pc, 32'hC);
        applyStimulus(4);

        // Branch redirect with two stale requests in a 3-cycle memory
        doReset();
        sLat = 3;
        applyStimulus(2);
        sBrV = 1'b1; sBrT = 32'h100;
        applyStimulus(1);
        sBrV = 1'b0;
        applyStimulus(2);
        checkOutput("lit_drop_req_valid", {31'b0, imem_req_valid}, 32'h0);
        applyStimulus(1);
        checkOutput("lit_redir_req_valid", {31'b0, imem_req_valid}, 32'h1);
        checkOutput("lit_redir_req_addr", imem_req_addr, 32'h100);
        applyStimulus(4);
        checkOutput("lit_redir_dec_pc", dec_pc, 32'h100);
        applyStimulus(6);

        // JALR wins over a simultaneous branch
        doReset();
        sLat = 1;
        applyStimulus(6);
        sJalrV = 1'b1; sJalrT = 32'h200; sBrV = 1'b1; sBrT = 32'h300;
        applyStimulus(1);
        sJalrV = 1'b0; sBrV = 1'b0;
        applyStimulus(1);
        checkOutput("lit_jalr_req_addr", imem_req_addr, 32'h200);
        applyStimulus(2);
        checkOutput("lit_jalr_dec_pc", dec_pc, 32'h200);
        applyStimulus(3);

        // Memory backpressure holds the address
        doReset();
        sReqReady = 1'b0;
        applyStimulus(5);
        checkOutput("lit_bp_req_valid", {31'b0, imem_req_valid}, 32'h1);
        checkOutput("lit_bp_req_addr", imem_req_addr, 32'h0);
        sReqReady = 1'b1;
        applyStimulus(2);
        checkOutput("lit_bp_next_addr", imem_req_addr, 32'h4);
        applyStimulus(3);
        sReqReady = 1'b0;
        applyStimulus(5);
        sReqReady = 1'b1;
        applyStimulus(5);

        // Asynchronous reset with three queued instructions
        doReset();
        sDecReady = 1'b0;
        applyStimulus(5);
        checkOutput("lit_prereset_valid", {31'b0, dec_valid}, 32'h1);
        sRst = 1'b0;
        applyStimulus(1);
        checkOutput("lit_midrst_dec_valid", {31'b0, dec_valid}, 32'h0);
        checkOutput("lit_midrst_dec_instr", dec_instr, 32'h0000_0013);
        sRst = 1'b1; sDecReady = 1'b1;
        applyStimulus(1);
        checkOutput("lit_refetch_addr", imem_req_addr, 32'h0);
        applyStimulus(6);

        // Mixed stalls, redirects and PC wraparound with a 2-cycle memory
        doReset();
        sLat = 2;
        for (int i = 0; i < 24; i++) begin
            sDecReady = ((i % 3) != 1);
            sReqReady = ((i % 5) != 2);
            sBrV = (i == 11); sBrT = 32'h0000_0400;
            sJalrV = (i == 17); sJalrT = 32'hFFFF_FFF8;
            applyStimulus(1);
        end
        sBrV = 1'b0; sJalrV = 1'b0; sDecReady = 1'b1; sReqReady = 1'b1;
        applyStimulus(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit_buffered.md
Name: fetch_unit_buffered

Overview:
Parametrised next-generation instruction fetch stage for the RV32IM 5-stage pipeline. Drives a handshaked instruction-memory port with multiple requests in flight and buffers returned instructions in an in-order fetch queue. Presents instructions to decode through a valid/ready interface. Redirects come from Execute (JALR over branch/JAL); a redirect flushes the queue and drops stale in-flight responses, so decode stalls no longer freeze the PC.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
RESET_PC, 32'h00000000, PC value after reset
FQ_DEPTH, 4, fetch-queue entries; power of two, >= 2; also caps requests in flight
NOP_INSTR, 32'h00000013, instruction driven on dec_instr when the queue is empty

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
jalr_valid  input  1  Execute-stage JALR redirect (JumpE & is_jalr_E)
jalr_target  input  XLEN  JALR target address
branch_valid  input  1  taken branch / JAL redirect (PCSrcE)
branch_target  input  XLEN  branch / JAL target address
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address
imem_rsp_valid  input  1  response valid; responses return in request order, one per request, no backpressure
imem_rsp_data  input  ILEN  fetched instruction
dec_valid  output  1  decode-side instruction valid
dec_ready  input  1  decode accepts (low = StallD)
dec_instr  output  ILEN  instruction at queue head
dec_pc  output  XLEN  PC of dec_instr
dec_pc_plus4  output  XLEN  dec_pc + 4

Behaviour:
- Reset (async, rst=0): pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, imem_req_valid=0, dec_valid=0, dec_instr=NOP_INSTR, dec_pc=0, dec_pc_plus4=0. Reset mid-operation discards everything immediately; responses for pre-reset requests are not expected.
- redirect = jalr_valid | branch_valid. Target priority: jalr_target, then branch_target.
- Issue: imem_req_valid = !redirect & (drop_cnt == 0) & (occupancy + outstanding < FQ_DEPTH). imem_req_addr = pc.
- Accepted request (valid & ready): pc <= pc + 4, mod 2^XLEN (wraps), outstanding += 1. Each request records its own PC in a PC FIFO of depth FQ_DEPTH.
- Response with drop_cnt == 0: push {instr, its PC} into the queue; outstanding -= 1. Credit rule guarantees the queue never overflows; overflow is an assertion failure.
- Response with drop_cnt > 0: discard, drop_cnt -= 1, outstanding -= 1.
- Redirect cycle: pc <= target; queue and PC FIFO flushed; no request issued; dec_valid still reflects the pre-flush head, but a pop in this cycle is ignored.
  - drop_cnt <= outstanding - (rsp_valid ? 1 : 0). A response arriving in the redirect cycle is discarded.
  - First request to the new target issues the cycle after drop_cnt reaches 0; earliest is the next cycle if nothing is outstanding.
- Dequeue: pop when dec_valid & dec_ready & !redirect. dec_valid = !empty. dec_* are driven from the queue-head registers, not combinationally from imem_rsp_data.
- Minimum latency: request accepted at cycle N, response at N+1 -> dec_valid at N+2.
- Simultaneous push and pop on a full queue is legal; occupancy is unchanged.
- Queue empty: dec_instr=NOP_INSTR, dec_pc=0, dec_pc_plus4=0.
- Full throughput: with a 1-cycle memory, dec_ready=1 and no redirect, one instruction per cycle after the first.
- Counters: occupancy and outstanding are each clog2(FQ_DEPTH)+1 bits wide.

Test Plan:
- Reset release, 1-cycle memory, dec_ready=1 -> imem_req_addr 0,4,8,... on consecutive cycles; dec_pc 0,4,8 from cycle 2; dec_pc_plus4 = dec_pc+4.
- dec_ready=0 for 10 cycles -> exactly FQ_DEPTH=4 requests issued (addrs 0..C), then imem_req_valid=0; on release, instrs 0,4,8,C pop in order with no loss.
- Branch redirect to 0x100 with 2 requests outstanding, 3-cycle memory -> both stale responses dropped; next request addr 0x100 after drop_cnt=0; first dec_pc=0x100.
- jalr_valid and branch_valid both high (0x200 vs 0x300) -> next fetch addr 0x200.
- imem_req_ready low 5 cycles, then high -> imem_req_addr held stable; no PC skip or duplicate.
- rst pulsed low mid-stream with queue at 3 entries -> dec_valid=0 and dec_instr=0x00000013 immediately; refetch from RESET_PC.
